// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, N steps per operation.
// Optional fast divide-by-zero path enabled by defining DIVIDER_ZERO_CHECK_EN.
//
// state  | meaning
// IDLE   | waiting for start; operands sampled here
// CALC   | one restoring step per edge, N edges total
// DONE   | results valid, done pulse, returns to IDLE next edge
module seq_divider #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   logic [1:0]    state;
   logic [N-1:0]  dvd;
   logic [N-1:0]  dvs;
   logic [N:0]    rem;
   logic [CW-1:0] cnt;

   logic [N+1:0]  trial;
   logic          ge;
   logic [N:0]    rem_nxt;
   logic [N-1:0]  quo_nxt;
   logic          zero_fast;

`ifdef DIVIDER_ZERO_CHECK_EN
   assign zero_fast = (divisor == '0);
`else
   assign zero_fast = 1'b0;
`endif

   // dvd shifts out dividend bits at the top and collects quotient bits at the bottom
   always_comb begin
      trial   = {rem, dvd[N-1]};
      ge      = (trial >= {2'b00, dvs});
      rem_nxt = trial[N:0];
      if (ge) begin
         rem_nxt = trial[N:0] - {1'b0, dvs};
      end
      quo_nxt = {dvd[N-2:0], ge};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         dvd       <= '0;
         dvs       <= '0;
         rem       <= '0;
         cnt       <= '0;
         quotient  <= '0;
         remainder <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (zero_fast) begin
                     quotient  <= '1;
                     remainder <= dividend;
                     state     <= S_DONE;
                  end else begin
                     dvd   <= dividend;
                     dvs   <= divisor;
                     rem   <= '0;
                     cnt   <= '0;
                     state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               dvd <= quo_nxt;
               rem <= rem_nxt;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  quotient  <= quo_nxt;
                  remainder <= rem_nxt[N-1:0];
                  state     <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef DIVIDER_ZERO_CHECK_EN
   logic dbz_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dbz_q <= 1'b0;
      end else if (state == S_IDLE && start && zero_fast) begin
         dbz_q <= 1'b1;
      end else if (state == S_CALC && cnt == LAST) begin
         dbz_q <= 1'b0;
      end
   end

   assign div_by_zero = dbz_q;
`else
   assign div_by_zero = 1'b0;
`endif

   assign busy = (state == S_CALC) || (state == S_DONE);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (N=4): stimulus pushes expected results,
// a negedge monitor pops and checks them whenever done is seen.
module tb_seq_divider;

   localparam int N = 4;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         busy;
   logic         done;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         div_by_zero;

   typedef struct {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         z;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   done_cnt = 0;

   seq_divider #(.N(N)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .dividend(dividend),
      .divisor(divisor),
      .busy(busy),
      .done(done),
      .quotient(quotient),
      .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // monitor
   always @(negedge clk) begin
      if (rst_n && done) begin
         done_cnt++;
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("quotient", int'(quotient), int'(e.q));
            chk("remainder", int'(remainder), int'(e.r));
            chk("div_by_zero", int'(div_by_zero), int'(e.z));
            chk("done_cycle", cyc, e.cyc);
         end
      end
   end

   // called at a negedge in IDLE; lat = edges from the start edge to the done edge
   task automatic do_start(input int a, input int b, input int q, input int r,
                           input int z, input int lat);
      exp_t e;
      start    = 1'b1;
      dividend = N'(a);
      divisor  = N'(b);
      e.q = N'(q);
      e.r = N'(r);
      e.z = z[0];
      e.cyc = cyc + 1 + lat;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (n >= 40) chk("idle_timeout", n, 0);
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (!done && t < 40) begin
         t++;
         @(negedge clk);
      end
      chk("done_timeout", int'(done), 1);
   endtask

   initial begin
      int n;
      int zlat;
      int zz;
      int zbusy;
      int dc;

      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_quotient", int'(quotient), 0);
      chk("rst_remainder", int'(remainder), 0);
      chk("rst_dbz", int'(div_by_zero), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 13/3 with operand inputs disturbed during CALC
      do_start(13, 3, 4, 1, 0, N);
      dividend = 4'd2;
      divisor  = 4'd9;
      wait_idle(n);
      chk("busy_cycles_13_3", n, 5);
      @(negedge clk);

      // 15/1 then 15/15 back-to-back; start also asserted during DONE
      do_start(15, 1, 15, 0, 0, N);
      wait_done();
      start    = 1'b1;
      dividend = 4'd15;
      divisor  = 4'd15;
      @(negedge clk);
      do_start(15, 15, 1, 0, 0, N);
      wait_idle(n);
      @(negedge clk);

      // divide by zero
`ifdef DIVIDER_ZERO_CHECK_EN
      zlat = 0; zz = 1; zbusy = 1;
`else
      zlat = N; zz = 0; zbusy = 5;
`endif
      do_start(7, 0, 15, 7, zz, zlat);
      wait_idle(n);
      chk("busy_cycles_7_0", n, zbusy);
      @(negedge clk);

      // boundary operands
      do_start(0, 7, 0, 0, 0, N);
      wait_idle(n);
      do_start(5, 9, 0, 5, 0, N);
      wait_idle(n);
      do_start(15, 2, 7, 1, 0, N);
      wait_idle(n);
      @(negedge clk);

      // 9/2 with a second request 14/7 held during CALC
      do_start(9, 2, 4, 1, 0, N);
      start    = 1'b1;
      dividend = 4'd14;
      divisor  = 4'd7;
      n = 0;
      while (busy && n < 40) begin
         if (done) start = 1'b0;
         n++;
         @(negedge clk);
      end
      start = 1'b0;
      chk("busy_cycles_9_2", n, 5);
      repeat (6) @(negedge clk);
      chk("hold_quotient", int'(quotient), 4);
      chk("hold_remainder", int'(remainder), 1);

      // reset during the second CALC cycle
      dc = done_cnt;
      start    = 1'b1;
      dividend = 4'd12;
      divisor  = 4'd5;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_quotient", int'(quotient), 0);
      chk("abort_remainder", int'(remainder), 0);
      chk("abort_dbz", int'(div_by_zero), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("abort_no_done", done_cnt, dc);

      do_start(12, 5, 2, 2, 0, N);
      wait_idle(n);
      repeat (3) @(negedge clk);

      chk("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation time exceeded, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The module SHALL have parameter N, default 4, giving the operand, quotient and remainder width in bits (N >= 2).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 The module SHALL have port dividend, input, N bits: unsigned dividend, sampled with start.
REQ-006 The module SHALL have port divisor, input, N bits: unsigned divisor, sampled with start.
REQ-007 The module SHALL have port busy, output, 1 bit: high while in CALC or DONE.
REQ-008 The module SHALL have port done, output, 1 bit: one-cycle pulse marking quotient/remainder valid.
REQ-009 The module SHALL have port quotient, output, N bits: registered unsigned quotient.
REQ-010 The module SHALL have port remainder, output, N bits: registered unsigned remainder.
REQ-011 The module SHALL have port div_by_zero, output, 1 bit: registered flag set with done when the divisor is 0.

Function
REQ-012 The FSM SHALL have exactly three states, IDLE, CALC and DONE, with IDLE entered on reset.
REQ-013 In IDLE, start=1 on rising edge E0 SHALL latch dividend and divisor, clear the N+1-bit partial remainder and the iteration counter, and enter CALC.
REQ-014 In CALC, each edge SHALL perform one restoring step: shift {partial remainder, dividend MSB} left by one bit, compare with zero-extended divisor, subtract if >=, and shift in quotient bit 1 if subtracted else 0.
REQ-015 Exactly N CALC steps SHALL occur, on E1..EN; at EN quotient and remainder (low N bits of the partial remainder) SHALL be registered, done SHALL be set, and the state SHALL become DONE.
REQ-016 DONE SHALL last exactly one cycle and then return to IDLE; done=1 only in DONE, so latency from the start edge to done visible is N cycles.
REQ-017 start asserted in CALC or DONE SHALL be ignored; start in the first IDLE cycle after DONE SHALL be accepted, giving a back-to-back period of N+2 cycles.
REQ-018 quotient, remainder and div_by_zero SHALL change only on the completion edge and SHALL hold their values until the next completion.
REQ-019 For divisor=0, the result SHALL be quotient = all ones and remainder = dividend, matching the natural restoring result.
REQ-020 Input changes on dividend or divisor after E0 SHALL NOT affect the running operation.

Reset
REQ-021 rst_n=0 SHALL immediately, without a clock, force state=IDLE and busy=0, done=0, quotient=0, remainder=0 and div_by_zero=0, and clear internal registers.
REQ-022 Reset asserted mid-CALC SHALL abort the operation with no done pulse, and the first start after release SHALL be processed normally.

Configuration
REQ-023 Macro DIVIDER_ZERO_CHECK_EN SHALL control divide-by-zero handling.
- Defined: a start with divisor=0 SHALL go IDLE->DONE at E0, with the REQ-019 results and div_by_zero=1 registered, so done is visible 1 cycle after the start edge.
- Not defined: a divisor of 0 SHALL run the normal N-step CALC, producing the same quotient and remainder, and div_by_zero SHALL be tied to 0.

Verification
REQ-024 N=4: start with 13/3 -> busy for 5 cycles (4 CALC, 1 DONE), done 4 cycles after start, quotient=4, remainder=1, div_by_zero=0.
REQ-025 N=4: 15/1 -> quotient=15, remainder=0; then 15/15 accepted in the cycle after DONE -> quotient=1, remainder=0, next done exactly 6 cycles after the previous done.
REQ-026 N=4: 7/0 with DIVIDER_ZERO_CHECK_EN -> done 1 cycle after start, quotient=15, remainder=7, div_by_zero=1; without the macro -> done after 4 cycles, quotient=15, remainder=7, div_by_zero=0.
REQ-027 N=4: start 9/2, then start=1 with 14/7 held throughout CALC -> one done only, quotient=4, remainder=1, and the second request is not accepted until IDLE.
REQ-028 N=4: start 12/5, rst_n low at 2nd CALC cycle -> all outputs 0 immediately, no done; after release, 12/5 -> quotient=2, remainder=2.
